// File: rtl/sram_arbiter.sv
// Two-requester arbiter sharing one single-port SRAM with an asynchronous read path.
// Grants are combinational, and read data comes back registered one cycle after the grant.
module sram_arbiter #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic                  sram_we,
    output logic                  sram_cs,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    logic                  prio_q, prio_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    // prio_q=1 hands a conflict to port 1. Nothing is granted while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (req0 && (!req1 || !ROUND_ROBIN || !prio_q)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        sram_cs   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        if (gnt0) begin
            sram_cs   = 1'b1;
            sram_we   = we0;
            sram_addr = addr0;
            sram_din  = wdata0;
        end else if (gnt1) begin
            sram_cs   = 1'b1;
            sram_we   = we1;
            sram_addr = addr1;
            sram_din  = wdata1;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (ROUND_ROBIN) begin
            if (gnt0) begin
                prio_d = 1'b1;
            end else if (gnt1) begin
                prio_d = 1'b0;
            end
        end
        rvalid0_d = gnt0 && !we0;
        rvalid1_d = gnt1 && !we1;
        rdata0_d  = rvalid0_d ? sram_dout : rdata0_q;
        rdata1_d  = rvalid1_d ? sram_dout : rdata1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            prio_q    <= prio_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vector table, hand-written reset/fixed-priority sequences,
// and randomized traffic scored against a simple served-last/memory reference model.
module tb_sram_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [7:0]  sramAddr;
    logic [15:0] sramDin, sramDout;
    logic        sramWe, sramCs;

    // Second instance with fixed priority (port 0 always wins)
    logic        zReq0, zWe0, zReq1, zWe1;
    logic [7:0]  zAddr0, zAddr1, zSramAddr;
    logic [15:0] zWdata0, zWdata1, zRdata0, zRdata1, zSramDin;
    logic        zGnt0, zGnt1, zRvalid0, zRvalid1, zSramWe, zSramCs;
    logic [15:0] zSramDout = 16'h5A3C;

    logic [15:0] mem [256];
    logic [15:0] refMem [256];

    int nVectors = 0;
    int nMiscompares = 0;

    typedef struct {
        logic r0; logic w0; logic [7:0] a0; logic [15:0] d0;
        logic r1; logic w1; logic [7:0] a1; logic [15:0] d1;
        logic g0; logic g1; logic cs; logic v0; logic v1;
        logic c0; logic [15:0] x0; logic c1; logic [15:0] x1;
    } vecT;

    vecT tbl[$];

    sram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .sram_addr(sramAddr), .sram_din(sramDin), .sram_we(sramWe),
        .sram_cs(sramCs), .sram_dout(sramDout)
    );

    sram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .ROUND_ROBIN(1'b0)) dutFixed (
        .clk(clk), .rst_n(rst_n),
        .req0(zReq0), .we0(zWe0), .addr0(zAddr0), .wdata0(zWdata0),
        .gnt0(zGnt0), .rvalid0(zRvalid0), .rdata0(zRdata0),
        .req1(zReq1), .we1(zWe1), .addr1(zAddr1), .wdata1(zWdata1),
        .gnt1(zGnt1), .rvalid1(zRvalid1), .rdata1(zRdata1),
        .sram_addr(zSramAddr), .sram_din(zSramDin), .sram_we(zSramWe),
        .sram_cs(zSramCs), .sram_dout(zSramDout)
    );

    always #5 clk = ~clk;

    assign sramDout = mem[sramAddr];

    always @(posedge clk) begin
        if (sramCs && sramWe) mem[sramAddr] <= sramDin;
    end

    task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [7:0] a0,
                                 input logic [15:0] d0, input logic r1, input logic w1,
                                 input logic [7:0] a1, input logic [15:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic checkOutput(input vecT v, input int idx);
        string tag;
        tag = $sformatf("row%0d", idx);
        checkOne({tag, ".gnt0"}, 32'(gnt0), 32'(v.g0));
        checkOne({tag, ".gnt1"}, 32'(gnt1), 32'(v.g1));
        checkOne({tag, ".sram_cs"}, 32'(sramCs), 32'(v.cs));
        checkOne({tag, ".rvalid0"}, 32'(rvalid0), 32'(v.v0));
        checkOne({tag, ".rvalid1"}, 32'(rvalid1), 32'(v.v1));
        if (v.c0) checkOne({tag, ".rdata0"}, 32'(rdata0), 32'(v.x0));
        if (v.c1) checkOne({tag, ".rdata1"}, 32'(rdata1), 32'(v.x1));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : mainSeq
        int lastServed;
        int winner;
        bit pend[2];
        logic pWe[2];
        logic [7:0] pAddr[2];
        logic [15:0] pData[2];
        logic mRv[2];
        logic [15:0] mRd[2];

        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        zReq0 = 1'b0; zWe0 = 1'b0; zAddr0 = 8'h20; zWdata0 = 16'h0F0F;
        zReq1 = 1'b0; zWe1 = 1'b0; zAddr1 = 8'h30; zWdata1 = 16'h0000;

        // Outputs must stay quiet during reset even with both ports requesting
        rst_n = 1'b0;
        applyStimulus(H, H, 8'h10, 16'h1111, H, L, 8'h20, 16'h2222);
        #12;
        checkOne("reset.gnt0", 32'(gnt0), 32'd0);
        checkOne("reset.gnt1", 32'(gnt1), 32'd0);
        checkOne("reset.sram_cs", 32'(sramCs), 32'd0);
        checkOne("reset.sram_we", 32'(sramWe), 32'd0);
        checkOne("reset.rvalid0", 32'(rvalid0), 32'd0);
        checkOne("reset.rvalid1", 32'(rvalid1), 32'd0);
        checkOne("reset.rdata0", 32'(rdata0), 32'd0);
        checkOne("reset.rdata1", 32'(rdata1), 32'd0);
        applyStimulus(L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl.push_back('{H, H, 8'h10, 16'hA5A5, L, L, 8'h00, 16'h0000, H, L, H, L, L, L, 16'h0000, L, 16'h0000});
        tbl.push_back('{H, L, 8'h10, 16'h0000, L, L, 8'h00, 16'h0000, H, L, H, L, L, L, 16'h0000, L, 16'h0000});
        tbl.push_back('{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, L, L, H, L, H, 16'hA5A5, L, 16'h0000});
        tbl.push_back('{L, L, 8'h00, 16'h0000, H, H, 8'hFF, 16'h1234, L, H, H, L, L, L, 16'h0000, L, 16'h0000});
        tbl.push_back('{H, L, 8'hFF, 16'h0000, L, L, 8'h00, 16'h0000, H, L, H, L, L, L, 16'h0000, L, 16'h0000});
        tbl.push_back('{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, L, L, H, L, H, 16'h1234, L, 16'h0000});
        tbl.push_back('{L, L, 8'h00, 16'h0000, H, L, 8'hFF, 16'h0000, L, H, H, L, L, L, 16'h0000, L, 16'h0000});
        tbl.push_back('{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, L, L, L, H, L, 16'h0000, H, 16'h1234});
        tbl.push_back('{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, L, L, L, L, H, 16'h1234, H, 16'h1234});
        tbl.push_back('{H, L, 8'h10, 16'h0000, H, L, 8'hFF, 16'h0000, H, L, H, L, L, L, 16'h0000, L, 16'h0000});
        tbl.push_back('{H, L, 8'h10, 16'h0000, H, L, 8'hFF, 16'h0000, L, H, H, H, L, H, 16'hA5A5, L, 16'h0000});
        tbl.push_back('{H, L, 8'h10, 16'h0000, H, L, 8'hFF, 16'h0000, H, L, H, L, H, L, 16'h0000, H, 16'h1234});
        tbl.push_back('{H, L, 8'h10, 16'h0000, H, L, 8'hFF, 16'h0000, L, H, H, H, L, H, 16'hA5A5, L, 16'h0000});
        tbl.push_back('{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, L, L, L, H, L, 16'h0000, H, 16'h1234});

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                          tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            checkOutput(tbl[i], i);
            @(posedge clk);
            #1;
        end

        // Reset during an in-flight read must clear rvalid/rdata and restore port-0 preference
        applyStimulus(H, L, 8'h10, 16'h0000, L, L, 8'h00, 16'h0000);
        @(negedge clk);
        checkOne("midrst.gnt0", 32'(gnt0), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(H, L, 8'h10, 16'h0000, H, L, 8'hFF, 16'h0000);
        checkOne("midrst.rvalid0_before", 32'(rvalid0), 32'd1);
        checkOne("midrst.rdata0_before", 32'(rdata0), 32'hA5A5);
        rst_n = 1'b0;
        #1;
        checkOne("midrst.rvalid0", 32'(rvalid0), 32'd0);
        checkOne("midrst.rdata0", 32'(rdata0), 32'd0);
        checkOne("midrst.rdata1", 32'(rdata1), 32'd0);
        checkOne("midrst.gnt0", 32'(gnt0), 32'd0);
        checkOne("midrst.gnt1", 32'(gnt1), 32'd0);
        checkOne("midrst.sram_cs", 32'(sramCs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOne("postrst.gnt0", 32'(gnt0), 32'd1);
        checkOne("postrst.gnt1", 32'(gnt1), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000);

        // Fixed-priority instance: port 0 wins every conflict until it drops its request
        zReq0 = 1'b1;
        zReq1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOne("fixed.gnt0", 32'(zGnt0), 32'd1);
            checkOne("fixed.gnt1", 32'(zGnt1), 32'd0);
            checkOne("fixed.sram_cs", 32'(zSramCs), 32'd1);
            checkOne("fixed.sram_we", 32'(zSramWe), 32'd0);
            checkOne("fixed.sram_addr", 32'(zSramAddr), 32'h20);
            checkOne("fixed.sram_din", 32'(zSramDin), 32'h0F0F);
            if (i > 0) begin
                checkOne("fixed.rvalid0", 32'(zRvalid0), 32'd1);
                checkOne("fixed.rdata0", 32'(zRdata0), 32'h5A3C);
            end
            @(posedge clk);
            #1;
        end
        zReq0 = 1'b0;
        @(negedge clk);
        checkOne("fixed.drop.gnt1", 32'(zGnt1), 32'd1);
        checkOne("fixed.drop.gnt0", 32'(zGnt0), 32'd0);
        checkOne("fixed.drop.sram_addr", 32'(zSramAddr), 32'h30);
        @(posedge clk);
        #1;
        zReq1 = 1'b0;
        @(negedge clk);
        checkOne("fixed.rvalid1", 32'(zRvalid1), 32'd1);
        checkOne("fixed.rdata1", 32'(zRdata1), 32'h5A3C);
        checkOne("fixed.rvalid0_off", 32'(zRvalid0), 32'd0);
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        doReset();
        for (int i = 0; i < 256; i++) refMem[i] = mem[i];
        lastServed = 1;
        mRv[0] = 1'b0; mRv[1] = 1'b0;
        mRd[0] = 16'h0000; mRd[1] = 16'h0000;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pWe[p] = 1'b0; pAddr[p] = 8'h00; pData[p] = 16'h0000;
        end

        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 3) != 0) begin
                    pend[p]  = 1'b1;
                    pWe[p]   = 1'($urandom_range(0, 1));
                    pAddr[p] = 8'($urandom_range(0, 15));
                    pData[p] = 16'($urandom);
                end
            end
            applyStimulus(pend[0], pWe[0], pAddr[0], pData[0], pend[1], pWe[1], pAddr[1], pData[1]);
            @(negedge clk);

            if (pend[0] && pend[1]) winner = (lastServed == 0) ? 1 : 0;
            else if (pend[0]) winner = 0;
            else if (pend[1]) winner = 1;
            else winner = -1;

            checkOne("rand.gnt0", 32'(gnt0), (winner == 0) ? 32'd1 : 32'd0);
            checkOne("rand.gnt1", 32'(gnt1), (winner == 1) ? 32'd1 : 32'd0);
            checkOne("rand.sram_cs", 32'(sramCs), (winner >= 0) ? 32'd1 : 32'd0);
            checkOne("rand.sram_we", 32'(sramWe), (winner >= 0) ? 32'(pWe[winner]) : 32'd0);
            checkOne("rand.sram_addr", 32'(sramAddr), (winner >= 0) ? 32'(pAddr[winner]) : 32'd0);
            checkOne("rand.sram_din", 32'(sramDin), (winner >= 0) ? 32'(pData[winner]) : 32'd0);
            checkOne("rand.rvalid0", 32'(rvalid0), 32'(mRv[0]));
            checkOne("rand.rvalid1", 32'(rvalid1), 32'(mRv[1]));
            checkOne("rand.rdata0", 32'(rdata0), 32'(mRd[0]));
            checkOne("rand.rdata1", 32'(rdata1), 32'(mRd[1]));

            mRv[0] = 1'b0;
            mRv[1] = 1'b0;
            if (winner >= 0) begin
                lastServed = winner;
                if (pWe[winner]) begin
                    refMem[pAddr[winner]] = pData[winner];
                end else begin
                    mRv[winner] = 1'b1;
                    mRd[winner] = refMem[pAddr[winner]];
                end
                pend[winner] = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
